// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog reset sequencer: FSM states,
// register addresses, CTRL bit positions and configuration reset values.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } wdt_state_e;

  localparam logic [5:0] ADDR_CTRL   = 6'h0;
  localparam logic [5:0] ADDR_GRACE  = 6'h1;
  localparam logic [5:0] ADDR_PULSE  = 6'h2;
  localparam logic [5:0] ADDR_STATUS = 6'h3;

  localparam int CTRL_ARM_BIT = 0;
  localparam int CTRL_ACK_BIT = 1;
  localparam int CTRL_CLR_BIT = 2;

  localparam int STATUS_WARN_BIT  = 0;
  localparam int STATUS_FIRED_BIT = 1;
  localparam int STATUS_LOCK_BIT  = 2;
  localparam int STATUS_CNT_LSB   = 8;
  localparam int STATUS_STATE_LSB = 16;

  localparam logic [31:0] GRACE_RST_VAL = 32'h0000_FFFF;
  localparam logic [31:0] PULSE_RST_VAL = 32'h0000_0010;

endpackage

// File: rtl/wdt_load_down_counter.sv
// Loadable down-counter that stops at zero and flags it; used for both the
// grace period and the reset-pulse width.
module wdt_load_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdt_reset_sequencer.sv
// Watchdog expiry -> early-warning interrupt -> grace period -> reset pulse.
// Optional macro WDT_RSTSEQ_LOCK_EN freezes ARM/GRACE/PULSE once armed.
//
// state | meaning
// IDLE  | waiting for an armed rising edge of expired_in
// WARN  | interrupt raised, grace counter running, ACK aborts
// PULSE | sys_rst_out asserted for max(PULSE,1) cycles
// HOLD  | waiting for expired_in to drop before re-arming
module wdt_reset_sequencer
  import wdt_pkg::*;
#(
  parameter int GRACE_W = 16,
  parameter int PULSE_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        expired_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        sys_rst_out,
  output logic        user_interrupt
);

  wdt_state_e         state_q;
  logic               irq_q, sys_rst_q;
  logic               exp_q, arm_q;
  logic [GRACE_W-1:0] grace_q;
  logic [PULSE_W-1:0] pulse_q;
  logic               warn_sticky_q, warn_sticky_d;
  logic               fired_sticky_q, fired_sticky_d;
  logic [CNT_W-1:0]   rst_count_q, rst_count_d;
  logic               cfg_locked;

  logic wr_en, ctrl_wr, ack_pulse, clr_pulse, exp_rise;
  logic warn_enter, abort, grace_zero, grace_expire, pulse_zero;
  logic [PULSE_W-1:0] pulse_load_val;

  assign wr_en     = (data_write_n != 2'b11);
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign ack_pulse = ctrl_wr && data_in[CTRL_ACK_BIT];
  assign clr_pulse = ctrl_wr && data_in[CTRL_CLR_BIT];
  assign exp_rise  = expired_in && !exp_q;

  assign warn_enter   = (state_q == ST_IDLE) && arm_q && exp_rise;
  assign abort        = ack_pulse || !arm_q;
  assign grace_expire = (state_q == ST_WARN) && !abort && grace_zero;
  // The counter exits on zero, so loading width-1 yields exactly width PULSE cycles.
  assign pulse_load_val = (pulse_q == '0) ? '0 : pulse_q - PULSE_W'(1);

  wdt_load_down_counter #(.W(GRACE_W)) u_grace_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (warn_enter),
    .load_val_i (grace_q),
    .dec_i      (state_q == ST_WARN),
    .zero_o     (grace_zero)
  );

  wdt_load_down_counter #(.W(PULSE_W)) u_pulse_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (grace_expire),
    .load_val_i (pulse_load_val),
    .dec_i      (state_q == ST_PULSE),
    .zero_o     (pulse_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      sys_rst_q <= 1'b0;
    end else begin
      irq_q     <= (state_q == ST_WARN);
      sys_rst_q <= (state_q == ST_PULSE);
      case (state_q)
        ST_IDLE:  if (warn_enter) state_q <= ST_WARN;
        ST_WARN: begin
          if (abort)           state_q <= ST_IDLE;
          else if (grace_zero) state_q <= ST_PULSE;
        end
        ST_PULSE: if (pulse_zero) state_q <= ST_HOLD;
        ST_HOLD:  if (!expired_in) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WDT_RSTSEQ_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (ctrl_wr && data_in[CTRL_ARM_BIT]) begin
      lock_q <= 1'b1;
    end
  end

  assign cfg_locked = lock_q;
`else
  assign cfg_locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= 1'b0;
      arm_q   <= 1'b0;
      grace_q <= GRACE_W'(GRACE_RST_VAL);
      pulse_q <= PULSE_W'(PULSE_RST_VAL);
    end else begin
      exp_q <= expired_in;
      if (ctrl_wr && !(cfg_locked && !data_in[CTRL_ARM_BIT])) begin
        arm_q <= data_in[CTRL_ARM_BIT];
      end
      if (wr_en && (address == ADDR_GRACE) && !cfg_locked) begin
        grace_q <= data_in[GRACE_W-1:0];
      end
      if (wr_en && (address == ADDR_PULSE) && !cfg_locked) begin
        pulse_q <= data_in[PULSE_W-1:0];
      end
    end
  end

  // A sticky set in the same cycle as CLR_STATUS survives the clear.
  always_comb begin
    warn_sticky_d  = clr_pulse ? 1'b0 : warn_sticky_q;
    fired_sticky_d = clr_pulse ? 1'b0 : fired_sticky_q;
    rst_count_d    = clr_pulse ? '0 : rst_count_q;
    if (warn_enter) warn_sticky_d = 1'b1;
    if (grace_expire) begin
      fired_sticky_d = 1'b1;
      if (rst_count_d != '1) rst_count_d = rst_count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_sticky_q  <= 1'b0;
      fired_sticky_q <= 1'b0;
      rst_count_q    <= '0;
    end else begin
      warn_sticky_q  <= warn_sticky_d;
      fired_sticky_q <= fired_sticky_d;
      rst_count_q    <= rst_count_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:  data_out[CTRL_ARM_BIT] = arm_q;
      ADDR_GRACE: data_out[GRACE_W-1:0] = grace_q;
      ADDR_PULSE: data_out[PULSE_W-1:0] = pulse_q;
      ADDR_STATUS: begin
        data_out[STATUS_WARN_BIT]              = warn_sticky_q;
        data_out[STATUS_FIRED_BIT]             = fired_sticky_q;
        data_out[STATUS_LOCK_BIT]              = cfg_locked;
        data_out[STATUS_CNT_LSB +: CNT_W]      = rst_count_q;
        data_out[STATUS_STATE_LSB +: 2]        = state_q;
      end
      default: data_out = '0;
    endcase
  end

  logic unused_bus;
  assign unused_bus = &{1'b0, data_read_n, data_in};

  assign data_ready     = 1'b1;
  assign sys_rst_out    = sys_rst_q;
  assign user_interrupt = irq_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Bench for wdt_reset_sequencer: each expiry scenario is predicted as cycle
// windows computed from grace/pulse/ACK/drop times and checked every cycle.
module tb_wdt_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        expired_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        sys_rst_out;
  logic        user_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  // expected sticky/counter/lock contents of STATUS
  int warn_m, fired_m, cnt_m, lock_m;

  localparam logic [5:0] A_CTRL = 6'h0, A_GRACE = 6'h1, A_PULSE = 6'h2, A_STATUS = 6'h3;

  wdt_reset_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .expired_in     (expired_in),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .sys_rst_out    (sys_rst_out),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
    address      = A_STATUS;
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
    address = A_STATUS;
  endtask

  function automatic logic [31:0] exp_status();
    return 32'((cnt_m << 8) | (lock_m << 2) | (fired_m << 1) | warn_m);
  endfunction

  task automatic reset_dut();
    rst        = 1'b1;
    expired_in = 1'b0;
    tick();
    rst = 1'b0;
    warn_m = 0; fired_m = 0; cnt_m = 0; lock_m = 0;
  endtask

  // mode 0: no ACK, 1: ACK at edge ka while warning, 2: ACK at edge ka during pulse
  task automatic run_trial(input int n, input int p, input int mode, input int ka);
    int pe, d, x, last_irq, len, st;
    bit acked, clr;
`ifdef WDT_RSTSEQ_LOCK_EN
    reset_dut();
`endif
    pe    = (p == 0) ? 1 : p;
    acked = (mode == 1);
    bus_write(A_GRACE, 32'(n));
    bus_write(A_PULSE, 32'(p));
    clr = ($urandom_range(0, 3) == 0);
    bus_write(A_CTRL, clr ? 32'h5 : 32'h1);
    lock_m = 0;
`ifdef WDT_RSTSEQ_LOCK_EN
    lock_m = 1;
`endif
    if (clr) begin warn_m = 0; fired_m = 0; cnt_m = 0; end

    if (acked) d = ka + int'($urandom_range(0, 3));
    else       d = n + 1 + pe + int'($urandom_range(0, 4));
    x        = (d > n + 3 + pe) ? d : n + 3 + pe;
    last_irq = acked ? ka : n + 2;
    len      = acked ? d + 2 : x + 2;

    for (int i = 1; i <= len; i++) begin
      expired_in = (i < d);
      if (mode != 0 && i == ka) begin
        address      = A_CTRL;
        data_in      = 32'h3;
        data_write_n = 2'b10;
      end
      tick();
      check($sformatf("irq@%0d", i), {31'b0, user_interrupt}, {31'b0, (i >= 2 && i <= last_irq)});
      check($sformatf("sysrst@%0d", i), {31'b0, sys_rst_out},
            {31'b0, (!acked && i >= n + 3 && i <= n + 2 + pe)});
      if (acked)               st = (i < ka) ? 1 : 0;
      else if (i <= n + 1)     st = 1;
      else if (i <= n + 1 + pe) st = 2;
      else if (i < x)          st = 3;
      else                     st = 0;
      check($sformatf("state@%0d", i), {30'b0, data_out[17:16]}, 32'(st));
    end

    warn_m = 1;
    if (!acked) begin
      fired_m = 1;
      if (cnt_m < 255) cnt_m++;
    end
    read_chk("status_end", A_STATUS, exp_status());
  endtask

  initial begin
    int seen;
    rst          = 1'b1;
    expired_in   = 1'b0;
    address      = A_STATUS;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    tick();
    tick();
    reset_dut();

    check("rst_sysrst", {31'b0, sys_rst_out}, 32'h0);
    check("rst_irq", {31'b0, user_interrupt}, 32'h0);
    check("ready", {31'b0, data_ready}, 32'h1);
    read_chk("rst_ctrl", A_CTRL, 32'h0);
    read_chk("rst_grace", A_GRACE, 32'h0000_FFFF);
    read_chk("rst_pulse", A_PULSE, 32'h0000_0010);
    read_chk("rst_status", A_STATUS, 32'h0);
    bus_write(6'h2A, 32'hFFFF_FFFF);
    read_chk("unmapped", 6'h2A, 32'h0);
    read_chk("grace_rw_before", A_GRACE, 32'h0000_FFFF);
    bus_write(A_GRACE, 32'h0001_1234);
    read_chk("grace_rw", A_GRACE, 32'h0000_1234);
    bus_write(A_CTRL, 32'h7);
    read_chk("ctrl_pulse_bits", A_CTRL, 32'h1);

`ifdef WDT_RSTSEQ_LOCK_EN
    reset_dut();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_GRACE, 32'h5);
    read_chk("lock_grace", A_GRACE, 32'h0000_FFFF);
    bus_write(A_CTRL, 32'h0);
    read_chk("lock_arm", A_CTRL, 32'h1);
    read_chk("lock_status", A_STATUS, 32'h4);
    reset_dut();
`else
    bus_write(A_CTRL, 32'h0);
    read_chk("arm_clear", A_CTRL, 32'h0);
    reset_dut();
`endif

    run_trial(10, 16, 1, 6);
    run_trial(3, 4, 0, 0);
    run_trial(0, 0, 0, 0);
    bus_write(A_CTRL, 32'h5);
    warn_m = 0; fired_m = 0; cnt_m = 0;
    read_chk("clr_status", A_STATUS, exp_status());
    run_trial(4, 2, 1, 6);
    run_trial(2, 3, 2, 6);

    for (int t = 0; t < 30; t++) begin
      int n, p, mode, pe, ka;
      n    = int'($urandom_range(0, 12));
      p    = int'($urandom_range(0, 6));
      pe   = (p == 0) ? 1 : p;
      mode = int'($urandom_range(0, 2));
      ka   = 0;
      if (mode == 1) ka = int'($urandom_range(2, n + 2));
      if (mode == 2) ka = int'($urandom_range(n + 3, n + 2 + pe));
      run_trial(n, p, mode, ka);
    end

    bus_write(A_GRACE, 32'h0);
    bus_write(A_PULSE, 32'h8);
    bus_write(A_CTRL, 32'h1);
    expired_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (sys_rst_out) seen = 1;
    end
    check("pulse_wait", 32'(seen), 32'h1);
    rst        = 1'b1;
    expired_in = 1'b0;
    tick();
    check("midrst_sysrst", {31'b0, sys_rst_out}, 32'h0);
    check("midrst_irq", {31'b0, user_interrupt}, 32'h0);
    rst = 1'b0;
    tick();
    read_chk("midrst_status", A_STATUS, 32'h0);
    read_chk("midrst_grace", A_GRACE, 32'h0000_FFFF);
    read_chk("midrst_ctrl", A_CTRL, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
